// File: rtl/stream_compare_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stream_compare_pkg
//  Purpose  : Shared types and helpers for the multi-channel stream comparator
//  Revision : 1.0 - initial release
// ============================================================================
package stream_compare_pkg;

  // Width of the trigger FSM state encoding as seen on trig_state.
  localparam int unsigned TRIG_STATE_W = 2;

  // Widest counter the saturating helper can handle.
  localparam int unsigned SAT_MAX_WIDTH = 64;

  typedef enum logic [TRIG_STATE_W-1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    TRIGGERED = 2'd2
  } trig_state_t;

  // Saturating increment for a counter that is 'width' bits wide, carried in a
  // 64-bit container so one function serves every counter width. The caller
  // truncates the result back to its own width.
  function automatic logic [SAT_MAX_WIDTH-1:0] sat_inc(
    input logic [SAT_MAX_WIDTH-1:0] value,
    input int unsigned              width
  );
    logic [SAT_MAX_WIDTH-1:0] max_val;
    if (width >= SAT_MAX_WIDTH) begin
      max_val = '1;
    end else begin
      max_val = (64'd1 << width) - 64'd1;
    end
    if (value >= max_val) begin
      return max_val;
    end
    return value + 64'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_compare_lane.sv
`default_nettype none
// ============================================================================
//  Module   : stream_compare_lane
//  Purpose  : Masked compare of one DUT channel against the reference plus its
//             saturating error counter
//  Revision : 1.0 - initial release
// ============================================================================
module stream_compare_lane
  import stream_compare_pkg::*;
#(
  parameter int unsigned TDATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   i_enable,
  input  logic                   i_beat,
  input  logic                   i_clear,
  input  logic [TDATA_WIDTH-1:0] i_dut_tdata,
  input  logic [TDATA_WIDTH-1:0] i_ref_tdata,
  input  logic [TDATA_WIDTH-1:0] i_data_mask,
  output logic                   o_miss,
  output logic [TDATA_WIDTH-1:0] o_xor,
  output logic [CNT_WIDTH-1:0]   o_err_count
);

  logic [TDATA_WIDTH-1:0] w_xor;
  logic                   w_miss;
  logic [CNT_WIDTH-1:0]   r_err_count;

  // Only masked bits can contribute to a mismatch.
  assign w_xor  = (i_dut_tdata ^ i_ref_tdata) & i_data_mask;
  assign w_miss = i_enable & i_beat & (|w_xor);

  assign o_miss      = w_miss;
  assign o_xor       = w_xor;
  assign o_err_count = r_err_count;

  // Per-channel error counter; clear wins over a same-cycle miss.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_err_count <= '0;
    end else if (i_clear) begin
      r_err_count <= '0;
    end else if (w_miss) begin
      r_err_count <= CNT_WIDTH'(sat_inc(SAT_MAX_WIDTH'(r_err_count), CNT_WIDTH));
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_compare_multi.sv
`default_nettype none
// ============================================================================
//  Module   : stream_compare_multi
//  Purpose  : Compares N_CH DUT AXI-Stream channels against one reference
//             stream; keeps error statistics, first-error capture and an
//             arm/threshold trigger for a logic analyser
//  Revision : 1.0 - initial release
// ============================================================================
module stream_compare_multi
  import stream_compare_pkg::*;
#(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned TDATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                        clk,
  input  logic                        aresetn,
  input  logic [TDATA_WIDTH-1:0]      s_ref_tdata,
  input  logic                        s_ref_tvalid,
  output logic                        s_ref_tready,
  input  logic [N_CH*TDATA_WIDTH-1:0] s_dut_tdata,
  input  logic [N_CH-1:0]             s_dut_tvalid,
  output logic [N_CH-1:0]             s_dut_tready,
  input  logic [N_CH-1:0]             ch_enable,
  input  logic [TDATA_WIDTH-1:0]      data_mask,
  input  logic [CNT_WIDTH-1:0]        err_threshold,
  input  logic                        ctrl_clear,
  input  logic                        ctrl_latch,
  input  logic                        ctrl_arm,
  output logic                        mismatch,
  output logic [N_CH-1:0]             mismatch_ch,
  output logic                        trig_out,
  output logic [1:0]                  trig_state,
  output logic [CNT_WIDTH-1:0]        word_count_lat,
  output logic [N_CH*CNT_WIDTH-1:0]   err_count_lat,
  output logic                        first_err_valid,
  output logic [CNT_WIDTH-1:0]        first_err_index,
  output logic [N_CH-1:0]             first_err_ch,
  output logic [TDATA_WIDTH-1:0]      first_err_xor
);

  logic                        w_beat;
  logic [N_CH-1:0]             w_miss;
  logic                        w_any_miss;
  logic [TDATA_WIDTH-1:0]      w_lane_xor [N_CH];
  logic [N_CH*CNT_WIDTH-1:0]   w_err_count;
  logic [TDATA_WIDTH-1:0]      w_first_xor;
  logic [CNT_WIDTH-1:0]        w_thr;
  logic [CNT_WIDTH-1:0]        w_arm_err_next;

  logic [CNT_WIDTH-1:0]        r_word_count;
  logic                        r_mismatch;
  logic [N_CH-1:0]             r_mismatch_ch;
  logic [CNT_WIDTH-1:0]        r_word_count_lat;
  logic [N_CH*CNT_WIDTH-1:0]   r_err_count_lat;
  logic                        r_first_err_valid;
  logic [CNT_WIDTH-1:0]        r_first_err_index;
  logic [N_CH-1:0]             r_first_err_ch;
  logic [TDATA_WIDTH-1:0]      r_first_err_xor;
  trig_state_t                 r_state;
  logic [CNT_WIDTH-1:0]        r_arm_err;
  logic                        r_trig_out;

  // A beat needs the reference plus every enabled channel; disabled channels
  // are held ready so their upstream drains instead of stalling.
  assign w_beat       = s_ref_tvalid & (&(s_dut_tvalid | ~ch_enable));
  assign s_ref_tready = w_beat;
  assign s_dut_tready = ~ch_enable | {N_CH{w_beat}};

  generate
    for (genvar g = 0; g < N_CH; g++) begin : g_lane
      stream_compare_lane #(
        .TDATA_WIDTH (TDATA_WIDTH),
        .CNT_WIDTH   (CNT_WIDTH)
      ) u_lane (
        .clk         (clk),
        .aresetn     (aresetn),
        .i_enable    (ch_enable[g]),
        .i_beat      (w_beat),
        .i_clear     (ctrl_clear),
        .i_dut_tdata (s_dut_tdata[g*TDATA_WIDTH +: TDATA_WIDTH]),
        .i_ref_tdata (s_ref_tdata),
        .i_data_mask (data_mask),
        .o_miss      (w_miss[g]),
        .o_xor       (w_lane_xor[g]),
        .o_err_count (w_err_count[g*CNT_WIDTH +: CNT_WIDTH])
      );
    end
  endgenerate

  assign w_any_miss = |w_miss;

  // Masked XOR of the lowest-numbered channel that mismatches this beat.
  always_comb begin
    w_first_xor = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (w_miss[i]) begin
        w_first_xor = w_lane_xor[i];
      end
    end
  end

  // A zero threshold behaves as one so the trigger can always fire.
  assign w_thr          = (err_threshold == '0) ? CNT_WIDTH'(1) : err_threshold;
  assign w_arm_err_next = CNT_WIDTH'(sat_inc(SAT_MAX_WIDTH'(r_arm_err), CNT_WIDTH));

  // Beat counter; a beat coincident with clear is accepted but not counted.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_word_count <= '0;
    end else if (ctrl_clear) begin
      r_word_count <= '0;
    end else if (w_beat) begin
      r_word_count <= CNT_WIDTH'(sat_inc(SAT_MAX_WIDTH'(r_word_count), CNT_WIDTH));
    end
  end

  // Per-beat mismatch flags, one cycle behind the beat.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_mismatch    <= 1'b0;
      r_mismatch_ch <= '0;
    end else begin
      r_mismatch    <= w_any_miss;
      r_mismatch_ch <= w_miss;
    end
  end

  // Snapshot of the counters as they stood before this edge's update.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_word_count_lat <= '0;
      r_err_count_lat  <= '0;
    end else if (ctrl_latch) begin
      r_word_count_lat <= r_word_count;
      r_err_count_lat  <= w_err_count;
    end
  end

  // First-error record, held until cleared.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_first_err_valid <= 1'b0;
      r_first_err_index <= '0;
      r_first_err_ch    <= '0;
      r_first_err_xor   <= '0;
    end else if (ctrl_clear) begin
      r_first_err_valid <= 1'b0;
      r_first_err_index <= '0;
      r_first_err_ch    <= '0;
      r_first_err_xor   <= '0;
    end else if (w_any_miss && !r_first_err_valid) begin
      r_first_err_valid <= 1'b1;
      r_first_err_index <= r_word_count;
      r_first_err_ch    <= w_miss;
      r_first_err_xor   <= w_first_xor;
    end
  end

  // Trigger FSM: clear dominates arm; errors accumulate only while armed.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= IDLE;
      r_arm_err  <= '0;
      r_trig_out <= 1'b0;
    end else begin
      r_trig_out <= 1'b0;
      if (ctrl_clear) begin
        r_state   <= IDLE;
        r_arm_err <= '0;
      end else if (ctrl_arm) begin
        r_state   <= ARMED;
        r_arm_err <= '0;
      end else begin
        case (r_state)
          ARMED: begin
            if (w_any_miss) begin
              r_arm_err <= w_arm_err_next;
              if (w_arm_err_next >= w_thr) begin
                r_state    <= TRIGGERED;
                r_trig_out <= 1'b1;
              end
            end
          end
          default: begin
            r_state <= r_state;
          end
        endcase
      end
    end
  end

  assign mismatch        = r_mismatch;
  assign mismatch_ch     = r_mismatch_ch;
  assign trig_out        = r_trig_out;
  assign trig_state      = r_state;
  assign word_count_lat  = r_word_count_lat;
  assign err_count_lat   = r_err_count_lat;
  assign first_err_valid = r_first_err_valid;
  assign first_err_index = r_first_err_index;
  assign first_err_ch    = r_first_err_ch;
  assign first_err_xor   = r_first_err_xor;

endmodule
`default_nettype wire

// File: tb/tb_stream_compare_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_compare_multi
//  Purpose  : Directed self-checking bench for stream_compare_multi
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stream_compare_multi;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] s_ref_tdata = '0;
  logic        s_ref_tvalid = 1'b0;
  logic [63:0] s_dut_tdata = '0;
  logic [1:0]  s_dut_tvalid = '0;
  logic [1:0]  ch_enable = 2'b11;
  logic [31:0] data_mask = '1;
  logic [31:0] err_threshold = '0;
  logic        ctrl_clear = 1'b0;
  logic        ctrl_latch = 1'b0;
  logic        ctrl_arm = 1'b0;

  logic        s_ref_tready;
  logic [1:0]  s_dut_tready;
  logic        mismatch;
  logic [1:0]  mismatch_ch;
  logic        trig_out;
  logic [1:0]  trig_state;
  logic [31:0] word_count_lat;
  logic [63:0] err_count_lat;
  logic        first_err_valid;
  logic [31:0] first_err_index;
  logic [1:0]  first_err_ch;
  logic [31:0] first_err_xor;

  // Narrow-counter instance for saturation behaviour.
  logic        u1_s_ref_tready;
  logic [1:0]  u1_s_dut_tready;
  logic        u1_mismatch;
  logic [1:0]  u1_mismatch_ch;
  logic        u1_trig_out;
  logic [1:0]  u1_trig_state;
  logic [3:0]  u1_word_count_lat;
  logic [7:0]  u1_err_count_lat;
  logic        u1_first_err_valid;
  logic [3:0]  u1_first_err_index;
  logic [1:0]  u1_first_err_ch;
  logic [31:0] u1_first_err_xor;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_compare_multi #(.N_CH(2), .TDATA_WIDTH(32), .CNT_WIDTH(32)) u_dut (
    .clk             (clk),
    .aresetn         (aresetn),
    .s_ref_tdata     (s_ref_tdata),
    .s_ref_tvalid    (s_ref_tvalid),
    .s_ref_tready    (s_ref_tready),
    .s_dut_tdata     (s_dut_tdata),
    .s_dut_tvalid    (s_dut_tvalid),
    .s_dut_tready    (s_dut_tready),
    .ch_enable       (ch_enable),
    .data_mask       (data_mask),
    .err_threshold   (err_threshold),
    .ctrl_clear      (ctrl_clear),
    .ctrl_latch      (ctrl_latch),
    .ctrl_arm        (ctrl_arm),
    .mismatch        (mismatch),
    .mismatch_ch     (mismatch_ch),
    .trig_out        (trig_out),
    .trig_state      (trig_state),
    .word_count_lat  (word_count_lat),
    .err_count_lat   (err_count_lat),
    .first_err_valid (first_err_valid),
    .first_err_index (first_err_index),
    .first_err_ch    (first_err_ch),
    .first_err_xor   (first_err_xor)
  );

  stream_compare_multi #(.N_CH(2), .TDATA_WIDTH(32), .CNT_WIDTH(4)) u_dut4 (
    .clk             (clk),
    .aresetn         (aresetn),
    .s_ref_tdata     (s_ref_tdata),
    .s_ref_tvalid    (s_ref_tvalid),
    .s_ref_tready    (u1_s_ref_tready),
    .s_dut_tdata     (s_dut_tdata),
    .s_dut_tvalid    (s_dut_tvalid),
    .s_dut_tready    (u1_s_dut_tready),
    .ch_enable       (ch_enable),
    .data_mask       (data_mask),
    .err_threshold   (err_threshold[3:0]),
    .ctrl_clear      (ctrl_clear),
    .ctrl_latch      (ctrl_latch),
    .ctrl_arm        (ctrl_arm),
    .mismatch        (u1_mismatch),
    .mismatch_ch     (u1_mismatch_ch),
    .trig_out        (u1_trig_out),
    .trig_state      (u1_trig_state),
    .word_count_lat  (u1_word_count_lat),
    .err_count_lat   (u1_err_count_lat),
    .first_err_valid (u1_first_err_valid),
    .first_err_index (u1_first_err_index),
    .first_err_ch    (u1_first_err_ch),
    .first_err_xor   (u1_first_err_xor)
  );

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One beat on both channels, then return to idle valids.
  task automatic send_beat(input logic [31:0] r, input logic [31:0] d0, input logic [31:0] d1);
    s_ref_tdata  = r;
    s_dut_tdata  = {d1, d0};
    s_ref_tvalid = 1'b1;
    s_dut_tvalid = 2'b11;
    step();
    s_ref_tvalid = 1'b0;
    s_dut_tvalid = 2'b00;
  endtask

  task automatic pulse_clear();
    ctrl_clear = 1'b1;
    step();
    ctrl_clear = 1'b0;
  endtask

  task automatic pulse_latch();
    ctrl_latch = 1'b1;
    step();
    ctrl_latch = 1'b0;
  endtask

  task automatic pulse_arm();
    ctrl_arm = 1'b1;
    step();
    ctrl_arm = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) step();
    aresetn = 1'b1;
    step();
    checks++;
    if ({mismatch, mismatch_ch, trig_out, trig_state} !== 6'd0) begin
      failures++;
      $display("FAIL reset_flags actual=%0h expected=0", {mismatch, mismatch_ch, trig_out, trig_state});
    end
    checks++;
    if ({word_count_lat, err_count_lat} !== 96'd0) begin
      failures++;
      $display("FAIL reset_lat actual=%0h expected=0", {word_count_lat, err_count_lat});
    end
    checks++;
    if ({first_err_valid, first_err_index, first_err_ch, first_err_xor} !== 67'd0) begin
      failures++;
      $display("FAIL reset_first_err actual=%0h expected=0",
               {first_err_valid, first_err_index, first_err_ch, first_err_xor});
    end
  endtask

  task automatic test_identical();
    int hits;
    hits = 0;
    ch_enable = 2'b11;
    data_mask = 32'hFFFF_FFFF;
    pulse_clear();
    for (int i = 0; i < 100; i++) begin
      send_beat(32'h1000 + i * 7, 32'h1000 + i * 7, 32'h1000 + i * 7);
      if (mismatch) hits++;
    end
    step();
    if (mismatch) hits++;
    pulse_latch();
    checks++;
    if (word_count_lat !== 32'd100) begin
      failures++;
      $display("FAIL ident_word_count actual=%0d expected=100", word_count_lat);
    end
    checks++;
    if (err_count_lat !== 64'd0) begin
      failures++;
      $display("FAIL ident_err_count actual=%0h expected=0", err_count_lat);
    end
    checks++;
    if (hits !== 0) begin
      failures++;
      $display("FAIL ident_mismatch_seen actual=%0d expected=0", hits);
    end
    checks++;
    if (first_err_valid !== 1'b0) begin
      failures++;
      $display("FAIL ident_first_err_valid actual=%0b expected=0", first_err_valid);
    end
  endtask

  // Ten beats, beat 5 has ch1 bit 8 flipped; expected outcome depends on mask.
  task automatic run_bit8_stream(input logic [31:0] mask, input logic expect_err);
    int hits;
    hits = 0;
    data_mask = mask;
    pulse_clear();
    for (int i = 0; i < 10; i++) begin
      logic [31:0] r;
      r = 32'hA5A5_0000 + i;
      send_beat(r, r, (i == 5) ? (r ^ 32'h0000_0100) : r);
      if (mismatch) hits++;
      if (expect_err && i == 5) begin
        checks++;
        if (mismatch !== 1'b1 || mismatch_ch !== 2'b10) begin
          failures++;
          $display("FAIL bit8_mismatch_latency actual=%0b/%0b expected=1/10", mismatch, mismatch_ch);
        end
      end
    end
    pulse_latch();
    checks++;
    if (hits !== (expect_err ? 1 : 0)) begin
      failures++;
      $display("FAIL bit8_mismatch_count actual=%0d expected=%0d", hits, expect_err ? 1 : 0);
    end
    checks++;
    if (err_count_lat !== (expect_err ? {32'd1, 32'd0} : 64'd0)) begin
      failures++;
      $display("FAIL bit8_err_count actual=%0h expected=%0h", err_count_lat,
               expect_err ? {32'd1, 32'd0} : 64'd0);
    end
    checks++;
    if (word_count_lat !== 32'd10) begin
      failures++;
      $display("FAIL bit8_word_count actual=%0d expected=10", word_count_lat);
    end
    checks++;
    if (first_err_valid !== expect_err) begin
      failures++;
      $display("FAIL bit8_first_err_valid actual=%0b expected=%0b", first_err_valid, expect_err);
    end
    if (expect_err) begin
      checks++;
      if (first_err_index !== 32'd5 || first_err_ch !== 2'b10 || first_err_xor !== 32'h0000_0100) begin
        failures++;
        $display("FAIL first_err_record actual=%0d/%0b/%0h expected=5/10/100",
                 first_err_index, first_err_ch, first_err_xor);
      end
    end
  endtask

  task automatic test_first_error();
    run_bit8_stream(32'hFFFF_FFFF, 1'b1);
  endtask

  task automatic test_mask();
    run_bit8_stream(32'hFFFF_00FF, 1'b0);
  endtask

  task automatic test_trigger();
    int pulses;
    pulses = 0;
    data_mask = 32'hFFFF_FFFF;
    err_threshold = 32'd3;
    pulse_clear();
    pulse_arm();
    checks++;
    if (trig_state !== 2'd1) begin
      failures++;
      $display("FAIL trig_armed actual=%0d expected=1", trig_state);
    end
    for (int i = 0; i < 10; i++) begin
      logic err;
      err = (i == 2) || (i == 4) || (i == 7);
      send_beat(32'h55 + i, err ? (32'h55 + i) ^ 32'h1 : 32'h55 + i, 32'h55 + i);
      if (trig_out) pulses++;
      if (i == 7) begin
        checks++;
        if (trig_out !== 1'b1 || mismatch !== 1'b1 || trig_state !== 2'd2) begin
          failures++;
          $display("FAIL trig_fire_beat7 actual=%0b/%0b/%0d expected=1/1/2", trig_out, mismatch, trig_state);
        end
      end
    end
    checks++;
    if (pulses !== 1) begin
      failures++;
      $display("FAIL trig_pulse_count actual=%0d expected=1", pulses);
    end
    pulse_arm();
    checks++;
    if (trig_state !== 2'd1) begin
      failures++;
      $display("FAIL trig_rearm actual=%0d expected=1", trig_state);
    end
    // Zero threshold fires on the first error.
    err_threshold = 32'd0;
    send_beat(32'h77, 32'h76, 32'h77);
    checks++;
    if (trig_out !== 1'b1 || trig_state !== 2'd2) begin
      failures++;
      $display("FAIL trig_thr_zero actual=%0b/%0d expected=1/2", trig_out, trig_state);
    end
    // Clear wins over a simultaneous arm.
    ctrl_clear = 1'b1;
    ctrl_arm   = 1'b1;
    step();
    ctrl_clear = 1'b0;
    ctrl_arm   = 1'b0;
    checks++;
    if (trig_state !== 2'd0) begin
      failures++;
      $display("FAIL trig_clear_beats_arm actual=%0d expected=0", trig_state);
    end
  endtask

  task automatic test_saturation();
    data_mask = 32'hFFFF_FFFF;
    pulse_clear();
    for (int i = 0; i < 20; i++) begin
      send_beat(i, i ^ 32'h1, i);
    end
    pulse_latch();
    checks++;
    if (u1_word_count_lat !== 4'd15 || u1_err_count_lat !== 8'h0F) begin
      failures++;
      $display("FAIL sat_counts actual=%0d/%0h expected=15/0f", u1_word_count_lat, u1_err_count_lat);
    end
    ctrl_clear = 1'b1;
    ctrl_latch = 1'b1;
    step();
    ctrl_clear = 1'b0;
    ctrl_latch = 1'b0;
    checks++;
    if (u1_word_count_lat !== 4'd15 || u1_err_count_lat !== 8'h0F) begin
      failures++;
      $display("FAIL sat_clear_latch actual=%0d/%0h expected=15/0f", u1_word_count_lat, u1_err_count_lat);
    end
    pulse_latch();
    checks++;
    if (u1_word_count_lat !== 4'd0 || u1_err_count_lat !== 8'h00) begin
      failures++;
      $display("FAIL sat_after_clear actual=%0d/%0h expected=0/0", u1_word_count_lat, u1_err_count_lat);
    end
  endtask

  task automatic test_disabled_channel();
    data_mask = 32'hFFFF_FFFF;
    ch_enable = 2'b01;
    pulse_clear();
    for (int i = 0; i < 5; i++) begin
      s_ref_tdata  = 32'h300 + i;
      s_dut_tdata  = {32'hDEAD_0000 + i, 32'h300 + i};
      s_ref_tvalid = 1'b1;
      s_dut_tvalid = 2'b01;
      #1;
      if (i == 0) begin
        checks++;
        if (s_ref_tready !== 1'b1 || s_dut_tready !== 2'b11) begin
          failures++;
          $display("FAIL dis_ready actual=%0b/%0b expected=1/11", s_ref_tready, s_dut_tready);
        end
      end
      step();
    end
    // Enabled channel not valid: no beat, disabled channel still drains.
    s_dut_tvalid = 2'b00;
    #1;
    checks++;
    if (s_ref_tready !== 1'b0 || s_dut_tready !== 2'b10) begin
      failures++;
      $display("FAIL dis_stall_ready actual=%0b/%0b expected=0/10", s_ref_tready, s_dut_tready);
    end
    s_ref_tvalid = 1'b0;
    step();
    pulse_latch();
    checks++;
    if (word_count_lat !== 32'd5 || err_count_lat !== 64'd0) begin
      failures++;
      $display("FAIL dis_counts actual=%0d/%0h expected=5/0", word_count_lat, err_count_lat);
    end
    // No channels enabled: reference alone forms the beat.
    ch_enable    = 2'b00;
    s_ref_tvalid = 1'b1;
    #1;
    checks++;
    if (s_ref_tready !== 1'b1 || s_dut_tready !== 2'b11) begin
      failures++;
      $display("FAIL none_enabled_ready actual=%0b/%0b expected=1/11", s_ref_tready, s_dut_tready);
    end
    step();
    s_ref_tvalid = 1'b0;
    ch_enable    = 2'b11;
    pulse_latch();
    checks++;
    if (word_count_lat !== 32'd6 || first_err_valid !== 1'b0) begin
      failures++;
      $display("FAIL none_enabled_count actual=%0d/%0b expected=6/0", word_count_lat, first_err_valid);
    end
  endtask

  task automatic test_async_reset();
    data_mask     = 32'hFFFF_FFFF;
    err_threshold = 32'd5;
    pulse_clear();
    pulse_arm();
    send_beat(32'h9, 32'h8, 32'h9);
    pulse_latch();
    checks++;
    if (first_err_valid !== 1'b1 || trig_state !== 2'd1 || word_count_lat !== 32'd1) begin
      failures++;
      $display("FAIL pre_reset_state actual=%0b/%0d/%0d expected=1/1/1",
               first_err_valid, trig_state, word_count_lat);
    end
    // Mismatching beat in flight, then reset between edges.
    s_ref_tdata  = 32'h10;
    s_dut_tdata  = {32'h10, 32'h11};
    s_ref_tvalid = 1'b1;
    s_dut_tvalid = 2'b11;
    step();
    #2;
    aresetn = 1'b0;
    #1;
    checks++;
    if ({mismatch, mismatch_ch, trig_out, trig_state, first_err_valid} !== 7'd0) begin
      failures++;
      $display("FAIL async_reset_flags actual=%0h expected=0",
               {mismatch, mismatch_ch, trig_out, trig_state, first_err_valid});
    end
    checks++;
    if ({word_count_lat, err_count_lat, first_err_index, first_err_ch, first_err_xor} !== 162'd0) begin
      failures++;
      $display("FAIL async_reset_regs actual=%0h expected=0",
               {word_count_lat, err_count_lat, first_err_index, first_err_ch, first_err_xor});
    end
    s_ref_tvalid = 1'b0;
    s_dut_tvalid = 2'b00;
    step();
    aresetn = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_identical();
    test_first_error();
    test_mask();
    test_trigger();
    test_saturation();
    test_disabled_channel();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_compare_multi.md
Name: stream_compare_multi

Overview:
- Parametrised successor to the two-stream comparator.
- Compares N_CH DUT AXI-Stream channels beat-for-beat against one reference stream, using a bit mask.
- Keeps saturating per-channel error counters, captures the first error, and drives an arm/threshold trigger FSM.
- Sits on loopback/test paths in front of a logic analyser; the control/status ports are fed by the register-decode wrapper.

Parameters:
- N_CH, 2, number of DUT channels (1..16).
- TDATA_WIDTH, 32, stream data width.
- CNT_WIDTH, 32, width of all counters and the threshold.

Ports:
- clk  in  1  single clock for all logic.
- aresetn  in  1  asynchronous, active-low reset.
- s_ref_tdata  in  TDATA_WIDTH  reference data.
- s_ref_tvalid  in  1  reference valid.
- s_ref_tready  out  1  reference ready.
- s_dut_tdata  in  N_CH*TDATA_WIDTH  DUT data; channel i occupies slice [i*W +: W].
- s_dut_tvalid  in  N_CH  DUT valids.
- s_dut_tready  out  N_CH  DUT readies.
- ch_enable  in  N_CH  channel participates in compare/handshake.
- data_mask  in  TDATA_WIDTH  1 = bit compared.
- err_threshold  in  CNT_WIDTH  mismatching beats after arm needed to trigger; 0 treated as 1.
- ctrl_clear  in  1  pulse: synchronous clear.
- ctrl_latch  in  1  pulse: snapshot counters.
- ctrl_arm  in  1  pulse: arm trigger.
- mismatch  out  1  registered per-beat mismatch pulse.
- mismatch_ch  out  N_CH  registered per-channel mismatch flags for that beat.
- trig_out  out  1  one-cycle trigger pulse.
- trig_state  out  2  current FSM state.
- word_count_lat  out  CNT_WIDTH  latched beat count.
- err_count_lat  out  N_CH*CNT_WIDTH  latched per-channel error counts.
- first_err_valid  out  1  first-error record valid.
- first_err_index  out  CNT_WIDTH  beat index of first error.
- first_err_ch  out  N_CH  channels mismatching at first error.
- first_err_xor  out  TDATA_WIDTH  masked XOR of the lowest mismatching channel.

Behaviour:
- Reset (aresetn low, asynchronous): every output and register is 0; FSM is IDLE.
- Handshake:
  - beat = s_ref_tvalid AND (s_dut_tvalid[i] for every enabled i).
  - s_ref_tready = beat.
  - s_dut_tready[i] = beat for enabled i; 1 for disabled i (the channel drains).
  - ready depends combinationally on valid; no buffering; throughput 1 beat/cycle.
  - ch_enable all 0: beat = s_ref_tvalid (reference only is counted, no errors).
- Compare:
  - miss[i] = enabled[i] AND beat AND |((dut_i XOR ref) AND data_mask).
  - data_mask = 0 means never mismatch.
- Counters (all saturate at all-ones and never wrap):
  - word_count += 1 per beat.
  - err_count[i] += 1 per miss[i].
  - arm_err += 1 per beat with any miss, counted only while ARMED.
- Latency: mismatch = |miss and mismatch_ch = miss, both one cycle after the beat.
- First error:
  - On the first beat with any miss while first_err_valid = 0, capture index = word_count before increment (0-based), ch = miss, xor = masked XOR of the lowest set channel.
  - Set first_err_valid.
  - Held until clear.
- Latch:
  - ctrl_latch copies the pre-update register values of word_count and err_count into the *_lat outputs on the next edge.
  - *_lat outputs hold otherwise.
- Clear:
  - ctrl_clear zeroes word_count, err_count, arm_err and the first-error record; FSM goes to IDLE.
  - A beat in the same cycle is still handshaken but not counted.
  - Latch in the same cycle captures the pre-clear values.
  - *_lat outputs are not cleared.
- FSM (IDLE=0, ARMED=1, TRIGGERED=2):
  - IDLE --arm--> ARMED, arm_err := 0.
  - ARMED --(arm_err + this beat's miss) >= max(threshold,1)--> TRIGGERED, with trig_out = 1 for exactly one cycle, aligned with mismatch.
  - TRIGGERED --arm--> ARMED (re-arm, arm_err := 0).
  - Any state --clear--> IDLE; clear beats arm when both are asserted.
  - Arm while ARMED restarts arm_err.
- Reset mid-packet: the partial beat is discarded; there is no recovery state.

Decomposition:
- Package stream_compare_pkg:
  - trig_state_t enum {IDLE, ARMED, TRIGGERED} (2 bits).
  - sat_inc function: saturating increment, CNT_WIDTH generic.
- Sub-module stream_compare_lane: masked compare plus saturating err_count for one channel; instantiated N_CH times via generate.
- Top: handshake, word counter, first-error capture, latch, FSM.

Test Plan:
- N_CH=2, 100 identical beats, latch -> word_count_lat=100, err_count_lat={0,0}, mismatch never high, first_err_valid=0.
- Beat 5 ch1 = ref^0x0000_0100, mask=0xFFFF_FFFF -> mismatch and mismatch_ch=2'b10 one cycle later; first_err_index=5, first_err_ch=2'b10, first_err_xor=0x100.
- Same stimulus with mask=0xFFFF_00FF -> no mismatch, err_count_lat={0,0}.
- Arm, threshold=3, errors on beats 2,4,7 -> trig_out single pulse aligned with beat-7 mismatch, trig_state=2; re-arm -> trig_state=1.
- CNT_WIDTH=4, 20 beats, all ch0 errors -> word_count_lat=15, err_count_lat[0]=15 (saturated); clear+latch same cycle -> lat=15, next latch -> 0.
- ch_enable=2'b01 with ch1 tvalid held 0 -> beats proceed, s_dut_tready[1]=1, err_count[1] stays 0; aresetn low mid-stream -> all outputs 0 asynchronously.
